// File: rtl/mdu_pkg.sv
// Shared op codes, state type and defaults for the multiply/divide sequencer.
// MDU_DIV_EN selects whether div/divu are recognised as long operations.
package mdu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
   localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
   localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
   localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
   localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
   localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
   localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   function automatic logic is_mul(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   // Without the divider, div/divu fall through as no-ops.
   function automatic logic is_div(input logic [OP_W-1:0] op);
`ifdef MDU_DIV_EN
      return (op == OP_DIV) || (op == OP_DIVU);
`else
      return 1'b0;
`endif
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic for the sequencer: 64-bit product or {remainder, quotient}.
// Divide logic exists only when MDU_DIV_EN is defined.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic [31:0]     a,
   input  logic [31:0]     b,
   output logic [63:0]     result,
   output logic            div_zero
);

`ifdef MDU_DIV_EN
   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] mag_q;
   logic [31:0] mag_r;
   logic [31:0] quo;
   logic [31:0] rem;
`endif

   // Operation select; signed divide works on magnitudes so 0x80000000/-1 needs no special case.
   always_comb begin
      result   = 64'd0;
      div_zero = 1'b0;
`ifdef MDU_DIV_EN
      neg_a = 1'b0;
      neg_b = 1'b0;
      mag_a = 32'd0;
      mag_b = 32'd0;
      mag_q = 32'd0;
      mag_r = 32'd0;
      quo   = 32'd0;
      rem   = 32'd0;
`endif
      case (op)
         OP_MULT:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         OP_MULTU: result = {32'd0, a} * {32'd0, b};
`ifdef MDU_DIV_EN
         OP_DIV, OP_DIVU: begin
            neg_a = (op == OP_DIV) & a[31];
            neg_b = (op == OP_DIV) & b[31];
            mag_a = neg_a ? (~a + 32'd1) : a;
            mag_b = neg_b ? (~b + 32'd1) : b;
            if (b == 32'd0) begin
               div_zero = 1'b1;
            end else begin
               mag_q  = mag_a / mag_b;
               mag_r  = mag_a % mag_b;
               quo    = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
               rem    = neg_a ? (~mag_r + 32'd1) : mag_r;
               result = {rem, quo};
            end
         end
`endif
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MDU sequencer owning HI/LO; result is computed at start and committed after the latency.
// Divide support is controlled by MDU_DIV_EN.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [31:0]     a,
   input  logic [31:0]     b,
   input  logic            cancel,
   output logic            busy,
   output logic            stall,
   output logic [31:0]     hi,
   output logic [31:0]     lo
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [63:0]   pending;
   logic          pend_wr;
   logic [63:0]   result;
   logic          div_zero;
   logic          accept;

   mdu_arith u_arith (
      .op       (op),
      .a        (a),
      .b        (b),
      .result   (result),
      .div_zero (div_zero)
   );

   assign accept = start & ~cancel;
   assign stall  = busy | (accept & (is_mul(op) | is_div(op)));

   // Sequencer FSM: latch result on start, count down, commit or abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         pending <= 64'd0;
         pend_wr <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && (is_mul(op) || is_div(op))) begin
                  pending <= result;
                  pend_wr <= ~div_zero;
                  cnt     <= is_mul(op) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                  state   <= S_RUN;
                  busy    <= 1'b1;
               end else if (accept && (op == OP_MTHI)) begin
                  hi <= a;
               end else if (accept && (op == OP_MTLO)) begin
                  lo <= a;
               end else begin
                  busy <= 1'b0;
               end
            end
            S_RUN: begin
               if (cancel) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == CW'(1)) begin
                  if (pend_wr) begin
                     hi <= pending[63:32];
                     lo <= pending[31:0];
                  end else begin
                     hi <= hi;
                  end
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
